// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: a DEPTH-entry circular FIFO between core stages
// with valid/ready on both sides, flush-to-NOP and an almost-full hint.
module elastic_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP       = '0,
    parameter int               AF_LEVEL  = DEPTH - 1,
    parameter bit               PASS_FULL = 1'b0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a beat transfers on a side only in a cycle where both its
    // valid and ready are high at the rising edge; ready never waits on valid.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign in_ready    = (count_q < CW'(DEPTH)) || (PASS_FULL && out_ready);
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : NOP;
    assign count       = count_q;
    assign almost_full = (int'(count_q) >= AF_LEVEL);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            // A pop completing this cycle is still seen downstream; nothing survives.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem_q[wr_ptr_q] <= in_data;
    end

    // Upstream must hold its payload while stalled (unless it flushes it away).
    a_in_data_stable : assert property (
        @(posedge clk) disable iff (reset)
        (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data))
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: three instances (DEPTH=2, DEPTH=2 with
// pass-through when full, DEPTH=3) driven one after another on a shared clock.
module tb_elastic_pipe_reg;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    // instance A: DEPTH=2, AF_LEVEL=1, PASS_FULL=0
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;
    // instance B: DEPTH=2, PASS_FULL=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;
    // instance C: DEPTH=3, PASS_FULL=0
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af;
    logic [31:0] c_in_data, c_out_data;
    logic [1:0]  c_count;

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .NOP(32'h13), .AF_LEVEL(1), .PASS_FULL(1'b0)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .almost_full(a_af)
    );

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .NOP(32'h13), .AF_LEVEL(1), .PASS_FULL(1'b1)) u_b (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .almost_full(b_af)
    );

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(3), .NOP(32'h0), .AF_LEVEL(2), .PASS_FULL(1'b0)) u_c (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count), .almost_full(c_af)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_empty(input string tag);
        check({tag, "_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_data"},  a_out_data,       32'h13);
        check({tag, "_count"}, 32'(a_count),     32'd0);
    endtask

    logic [15:0] c_psh;
    logic [15:0] c_pop;
    int          mcnt;
    logic [31:0] c_next;
    logic        acc_push, acc_pop;

    initial begin
        reset = 1'b1; flush = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
        step(); step();
        reset = 1'b0;

        // reset state
        check_a_empty("rst_a");
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_a_af",       32'(a_af),       32'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        check("rst_c_count",    32'(c_count),    32'd0);

        // push A, B with downstream stalled
        a_in_valid = 1; a_in_data = 32'hA;
        step();
        check("ab_count1", 32'(a_count), 32'd1);
        check("ab_af1",    32'(a_af),    32'd1);
        check("ab_rdy1",   32'(a_in_ready), 32'd1);
        check("ab_head1",  a_out_data,   32'hA);
        a_in_data = 32'hB;
        step();
        check("ab_count2", 32'(a_count), 32'd2);
        check("ab_rdy2",   32'(a_in_ready), 32'd0);
        check("ab_head2",  a_out_data,   32'hA);
        a_in_valid = 0; a_out_ready = 1;
        step();
        check("ab_popA",   a_out_data,   32'hB);
        check("ab_cnt_pA", 32'(a_count), 32'd1);
        step();
        check_a_empty("ab_drain");
        a_out_ready = 0;

        // streaming 1..100, one per cycle after one cycle of latency
        a_out_ready = 1;
        for (int i = 1; i <= 100; i++) begin
            a_in_valid = 1; a_in_data = 32'(i);
            step();
            check("stream_data",  a_out_data,   32'(i));
            check("stream_count", 32'(a_count), 32'd1);
        end
        a_in_valid = 0;
        step();
        check_a_empty("stream_end");
        a_out_ready = 0;

        // pass-through when full (instance B)
        b_in_valid = 1; b_in_data = 32'hC;
        step();
        b_in_data = 32'hD;
        step();
        check("pf_count_full", 32'(b_count), 32'd2);
        check("pf_rdy_stall",  32'(b_in_ready), 32'd0);
        b_in_data = 32'hE; b_out_ready = 1;
        #1;
        check("pf_rdy_pass", 32'(b_in_ready), 32'd1);
        check("pf_head_C",   b_out_data,      32'hC);
        step();
        check("pf_count_kept", 32'(b_count), 32'd2);
        check("pf_head_D",     b_out_data,   32'hD);
        b_in_valid = 0;
        step();
        check("pf_head_E", b_out_data,   32'hE);
        check("pf_cnt_E",  32'(b_count), 32'd1);
        step();
        check("pf_empty_valid", 32'(b_out_valid), 32'd0);
        check("pf_empty_data",  b_out_data,       32'h13);
        b_out_ready = 0;

        // DEPTH=3 wrap with scoreboard
        c_psh = 16'b1110_0011_1111_1111;
        c_pop = 16'b1111_1101_1111_0000;
        mcnt = 0; c_next = 32'h30;
        for (int i = 0; i < 16; i++) begin
            c_in_valid = c_psh[i]; c_in_data = c_next; c_out_ready = c_pop[i];
            acc_push = c_psh[i] && (mcnt < 3);
            acc_pop  = c_pop[i] && (mcnt > 0);
            check("wrap_in_ready", 32'(c_in_ready), 32'(mcnt < 3));
            if (acc_pop) begin
                check("wrap_head", c_out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (acc_push) exp_q.push_back(c_next);
            step();
            mcnt = mcnt + int'(acc_push) - int'(acc_pop);
            if (acc_push) c_next++;
            check("wrap_count", 32'(c_count), 32'(mcnt));
        end
        c_in_valid = 0; c_out_ready = 1;
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            check("drain_head", c_out_data, exp_q[0]);
            void'(exp_q.pop_front());
            step();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(c_out_valid), 32'd0);
        c_out_ready = 0;

        // flush with two held entries and a beat offered
        a_in_valid = 1; a_in_data = 32'h1;
        step();
        a_in_data = 32'h2;
        step();
        flush = 1; a_in_data = 32'hF;
        step();
        flush = 0; a_in_valid = 0;
        check_a_empty("flush2");
        check("flush2_rdy", 32'(a_in_ready), 32'd1);
        step();
        check_a_empty("flush2_after");

        // flush with one entry, in_ready=1 and a pop in the same cycle
        a_in_valid = 1; a_in_data = 32'h5;
        step();
        flush = 1; a_in_data = 32'hF; a_out_ready = 1;
        check("flush1_rdy", 32'(a_in_ready), 32'd1);
        step();
        flush = 0; a_in_valid = 0; a_out_ready = 0;
        check_a_empty("flush1");
        step();
        check_a_empty("flush1_after");

        // reset together with flush
        a_in_valid = 1; a_in_data = 32'h7;
        step();
        a_in_data = 32'h8;
        step();
        reset = 1; flush = 1; a_in_data = 32'hF;
        step();
        flush = 0;
        check_a_empty("rstfl");
        check("rstfl_rdy", 32'(a_in_ready), 32'd1);
        check("rstfl_af",  32'(a_af),       32'd0);
        step();
        check_a_empty("rstfl_hold");
        a_in_valid = 0; reset = 0;
        step();
        check_a_empty("rstfl_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
